mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter ALUCTL_W, default 3: alucontrol width; codes occupy bits [2:0], upper bits driven 0; SHALL be >= 3.
REQ-002 Parameter ILLEGAL_HALT, default 0: 1 = illegal opcode enters HALT, 0 = illegal opcode returns to FETCH.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 op  input  6  instruction opcode (instr[31:26]).
REQ-006 funct  input  6  R-type function field (instr[5:0]).
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access complete (used only with MEMREADY_EN).
REQ-009 memtoreg, memwrite, pcen, alusrca, regdst, regwrite, irwrite, lord  output  1 each  datapath controls, same meaning as the current multicycle datapath.
REQ-010 pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 alusrcb  output  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-012 alucontrol  output  ALUCTL_W  ALU operation.
REQ-013 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-014 state  output  4  current FSM state, debug.

Function
REQ-015 Supported ops: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
REQ-016 States (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQ 8, BNE 9, ADDIEX 10, ADDIWB 11, JUMP 12, HALT 15.
REQ-017 FETCH: lord=0, alusrca=0, alusrcb=01, aluop add, pcsrc=00, irwrite=1, pcwrite=1; next DECODE.
REQ-018 DECODE: alusrca=0, alusrcb=11, aluop add; next by op: lw/sw->MEMADR, R->EXECUTE, beq->BEQ, bne->BNE, addi->ADDIEX, j->JUMP, other->illegal path (REQ-025).
REQ-019 MEMADR: alusrca=1, alusrcb=10, add; lw->MEMRD, sw->MEMWR. MEMRD: lord=1 -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH. MEMWR: lord=1, memwrite=1 -> FETCH.
REQ-020 EXECUTE: alusrca=1, alusrcb=00, funct decode -> ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-021 BEQ/BNE: alusrca=1, alusrcb=00, sub, pcsrc=01, branch-type asserted -> FETCH. ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB (regdst=0, memtoreg=0, regwrite=1) -> FETCH. JUMP: pcsrc=10, pcwrite=1 -> FETCH.
REQ-022 pcen = pcwrite | (beq-state & zero) | (bne-state & ~zero), combinational from state and zero.
REQ-023 ALU codes: add 010, sub 110, and 000, or 001, slt 111. Funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> add, no illegal pulse.
REQ-024 All controls not listed for a state SHALL be 0 (alusrcb 00, pcsrc 00, alucontrol add).
REQ-025 Illegal opcode in DECODE: illegal=1 that cycle; next HALT if ILLEGAL_HALT=1, else FETCH. HALT: all write enables 0, illegal 0, held until reset.
REQ-026 Outputs other than pcen and memwrite/irwrite gating (REQ-030) SHALL be Moore decodes of state.

Reset
REQ-027 reset low asynchronously forces state=FETCH, independent of clk; honoured in any state including mid-access and HALT.
REQ-028 While reset low: regwrite, memwrite, illegal=0; irwrite, pcen, memwrite SHALL NOT act before first rising clk after release.
REQ-029 First rising clk after release executes FETCH.

Configuration
REQ-030 Macro MIPS_MC_MEMREADY_EN defined: FETCH, MEMRD, MEMWR hold until mem_ready=1; in FETCH irwrite and pcwrite are asserted only while mem_ready=1; memwrite held high during MEMWR wait; MEMRD advances to MEMWB only when mem_ready=1.
REQ-031 Macro undefined: mem_ready ignored, every state lasts one cycle (lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3 cycles).

Verification
REQ-032 reset low mid-EXECUTE -> state=0 immediately, regwrite=0; release -> FETCH with irwrite=1, pcen=1 next edge.
REQ-033 op=100011, macro undefined -> states 0,1,2,3,4, regwrite=1 and memtoreg=1 in state 4 only, back to 0.
REQ-034 op=101011, macro defined, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, state 5 held, then 0.
REQ-035 op=000101, zero=0 -> pcen=1 in BNE; zero=1 -> pcen=0; beq mirrored.
REQ-036 R-type funct=101010 -> alucontrol=111 in EXECUTE; funct=000000 -> 010, illegal=0.
REQ-037 op=111111, ILLEGAL_HALT=1 -> illegal pulse 1 cycle, state=15 held 10 cycles with all enables 0; ILLEGAL_HALT=0 -> state 0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control unit.
// A two-process FSM that sequences fetch, decode, memory, ALU, branch and
// jump states and drives the datapath controls for each state.
// Optional build macro: MIPS_MC_MEMREADY_EN. When it is defined, FETCH,
// MEMRD and MEMWR wait for mem_ready. When it is undefined, mem_ready is
// ignored and every state lasts one cycle.
module mips_mc_ctrl #(
  parameter int ALUCTL_W     = 3,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                memtoreg,
  output logic                memwrite,
  output logic                pcen,
  output logic                alusrca,
  output logic                regdst,
  output logic                regwrite,
  output logic                irwrite,
  output logic                lord,
  output logic [1:0]          pcsrc,
  output logic [1:0]          alusrcb,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_BNE     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_ok;
  logic       w_pcwrite;
  logic       w_beq;
  logic       w_bne;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_illegal;
  logic [2:0] w_alu;

`ifdef MIPS_MC_MEMREADY_EN
  assign w_mem_ok = mem_ready;
`else
  // Memory always completes in one cycle; mem_ready is deliberately ignored.
  logic w_unused_mem;
  assign w_unused_mem = mem_ready;
  assign w_mem_ok     = 1'b1;
`endif

  // State register; an asynchronous reset returns the FSM to FETCH from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and per-state control decode; every control defaults to inactive.
  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_beq      = 1'b0;
    w_bne      = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_alu      = ALU_ADD;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    regdst     = 1'b0;
    lord       = 1'b0;
    pcsrc      = 2'b00;
    alusrcb    = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = w_mem_ok;
        w_pcwrite = w_mem_ok;
        w_next    = w_mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BEQ;
          OP_BNE:       w_next = S_BNE;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        lord   = 1'b1;
        w_next = w_mem_ok ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        lord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = w_mem_ok ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: w_alu = ALU_SUB;
          6'b100100: w_alu = ALU_AND;
          6'b100101: w_alu = ALU_OR;
          6'b101010: w_alu = ALU_SLT;
          default:   w_alu = ALU_ADD;
        endcase
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alusrca = 1'b1;
        w_alu   = ALU_SUB;
        pcsrc   = 2'b01;
        w_beq   = (r_state == S_BEQ);
        w_bne   = (r_state == S_BNE);
        w_next  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are held off while reset is asserted so nothing acts before release.
  always_comb begin
    alucontrol      = '0;
    alucontrol[2:0] = w_alu;
    irwrite         = w_irwrite & reset;
    memwrite        = w_memwrite & reset;
    regwrite        = w_regwrite & reset;
    illegal         = w_illegal & reset;
    pcen            = (w_pcwrite | (w_beq & zero) | (w_bne & ~zero)) & reset;
  end

  assign state = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed testbench for mips_mc_ctrl. Two instances share all inputs:
// u_dut uses ILLEGAL_HALT=0, u_dut_h uses ILLEGAL_HALT=1.
module tb_mips_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       memtoreg, memwrite, pcen, alusrca, regdst, regwrite, irwrite, lord, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       h_memtoreg, h_memwrite, h_pcen, h_alusrca, h_regdst, h_regwrite, h_irwrite;
  logic       h_lord, h_illegal;
  logic [1:0] h_pcsrc, h_alusrcb;
  logic [2:0] h_alucontrol;
  logic [3:0] h_state;

  int n_pass;
  int n_total;

  mips_mc_ctrl #(.ALUCTL_W(3), .ILLEGAL_HALT(0)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memtoreg(memtoreg), .memwrite(memwrite), .pcen(pcen), .alusrca(alusrca),
    .regdst(regdst), .regwrite(regwrite), .irwrite(irwrite), .lord(lord),
    .pcsrc(pcsrc), .alusrcb(alusrcb), .alucontrol(alucontrol), .illegal(illegal),
    .state(state)
  );

  mips_mc_ctrl #(.ALUCTL_W(3), .ILLEGAL_HALT(1)) u_dut_h (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memtoreg(h_memtoreg), .memwrite(h_memwrite), .pcen(h_pcen), .alusrca(h_alusrca),
    .regdst(h_regdst), .regwrite(h_regwrite), .irwrite(h_irwrite), .lord(h_lord),
    .pcsrc(h_pcsrc), .alusrcb(h_alusrcb), .alucontrol(h_alucontrol), .illegal(h_illegal),
    .state(h_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [5];
  logic [2:0] alu_tab [5];

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b0;
    op        = 6'b100011;
    funct     = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    fn_tab[0] = 6'b100000; alu_tab[0] = 3'b010;
    fn_tab[1] = 6'b100010; alu_tab[1] = 3'b110;
    fn_tab[2] = 6'b100100; alu_tab[2] = 3'b000;
    fn_tab[3] = 6'b100101; alu_tab[3] = 3'b001;
    fn_tab[4] = 6'b101010; alu_tab[4] = 3'b111;

    // reset state
    #1;
    chk("rst_state", state, 0);
    chk("rst_regwrite", regwrite, 0);
    chk("rst_memwrite", memwrite, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_irwrite", irwrite, 0);
    tick();
    chk("rst_held_state", state, 0);
    chk("rst_held_pcen", pcen, 0);
    #2 reset = 1'b1;
    #1;
    // lw: 0,1,2,3,4,0
    chk("fetch_irwrite", irwrite, 1);
    chk("fetch_pcen", pcen, 1);
    chk("fetch_alusrcb", alusrcb, 2'b01);
    chk("fetch_alu", alucontrol, 3'b010);
    tick(); chk("lw_s1", state, 1); chk("dec_alusrcb", alusrcb, 2'b11);
    chk("dec_pcen", pcen, 0);
    tick(); chk("lw_s2", state, 2); chk("madr_alusrca", alusrca, 1);
    chk("madr_alusrcb", alusrcb, 2'b10);
    tick(); chk("lw_s3", state, 3); chk("mrd_lord", lord, 1); chk("mrd_regwrite", regwrite, 0);
    tick(); chk("lw_s4", state, 4); chk("mwb_regwrite", regwrite, 1);
    chk("mwb_memtoreg", memtoreg, 1); chk("mwb_regdst", regdst, 0);
    tick(); chk("lw_s0", state, 0); chk("lw_end_regwrite", regwrite, 0);
    chk("lw_end_memtoreg", memtoreg, 0);

    // sw: 0,1,2,5,0
    op = 6'b101011;
    tick(); chk("sw_s1", state, 1);
    tick(); chk("sw_s2", state, 2);
    tick(); chk("sw_s5", state, 5); chk("mwr_memwrite", memwrite, 1); chk("mwr_lord", lord, 1);
    tick(); chk("sw_s0", state, 0); chk("sw_end_memwrite", memwrite, 0);

`ifdef MIPS_MC_MEMREADY_EN
    // sw with memory stalling three cycles in MEMWR
    tick(); tick(); tick();
    chk("swr_s5", state, 5);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("swr_wait_state", state, 5);
      chk("swr_wait_memwrite", memwrite, 1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("swr_last_memwrite", memwrite, 1);
    tick(); chk("swr_s0", state, 0);
    // FETCH stalls with irwrite/pcen low until mem_ready
    mem_ready = 1'b0;
    #1;
    chk("fst_irwrite", irwrite, 0); chk("fst_pcen", pcen, 0);
    tick(); chk("fst_state", state, 0);
    mem_ready = 1'b1;
    #1;
    chk("fst_go_irwrite", irwrite, 1);
    tick(); chk("fst_s1", state, 1);
    tick(); tick(); tick(); chk("fst_back", state, 0);
`endif

    // R-type across the funct table
    op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = fn_tab[i];
      tick(); chk("r_s1", state, 1);
      tick(); chk("r_s6", state, 6); chk("ex_alu", alucontrol, {29'd0, alu_tab[i]});
      chk("ex_alusrcb", alusrcb, 2'b00); chk("ex_alusrca", alusrca, 1);
      tick(); chk("r_s7", state, 7); chk("awb_regwrite", regwrite, 1); chk("awb_regdst", regdst, 1);
      tick(); chk("r_s0", state, 0);
    end
    // unknown funct defaults to add without an illegal pulse
    funct = 6'b000000;
    tick(); chk("rf0_illegal_dec", illegal, 0);
    tick(); chk("rf0_alu", alucontrol, 3'b010); chk("rf0_illegal", illegal, 0);
    tick(); tick(); chk("rf0_s0", state, 0);

    // bne / beq with both zero values
    op = 6'b000101; zero = 1'b0;
    tick(); tick(); chk("bne_s9", state, 9); chk("bne_nz_pcen", pcen, 1);
    chk("bne_pcsrc", pcsrc, 2'b01); chk("bne_alu", alucontrol, 3'b110);
    tick(); chk("bne_s0", state, 0);
    zero = 1'b1;
    tick(); tick(); chk("bne_z_pcen", pcen, 0);
    tick();
    op = 6'b000100;
    tick(); tick(); chk("beq_s8", state, 8); chk("beq_z_pcen", pcen, 1);
    zero = 1'b0;
    #1 chk("beq_nz_pcen", pcen, 0);
    tick(); chk("beq_s0", state, 0);

    // addi: 0,1,10,11,0
    op = 6'b001000;
    tick(); tick(); chk("addi_s10", state, 10); chk("addi_alusrcb", alusrcb, 2'b10);
    tick(); chk("addi_s11", state, 11); chk("addi_regwrite", regwrite, 1);
    chk("addi_regdst", regdst, 0); chk("addi_memtoreg", memtoreg, 0);
    tick(); chk("addi_s0", state, 0);

    // j: 0,1,12,0
    op = 6'b000010;
    tick(); tick(); chk("j_s12", state, 12); chk("j_pcsrc", pcsrc, 2'b10); chk("j_pcen", pcen, 1);
    tick(); chk("j_s0", state, 0);

    // illegal opcode: both instances pulse; only the halting one parks in HALT
    op = 6'b111111;
    tick(); chk("ill_pulse", illegal, 1); chk("ill_pulse_h", h_illegal, 1);
    tick(); chk("ill_ret_state", state, 0); chk("ill_halt_state", h_state, 15);
    chk("ill_pulse_end_h", h_illegal, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_state", h_state, 15);
      chk("halt_enables", {h_regwrite, h_memwrite, h_irwrite, h_pcen, h_illegal}, 0);
    end

    // reset asserted mid-EXECUTE
    op = 6'b000000; funct = 6'b100000;
    @(posedge clk); #1;
    while (state != 0) tick();
    tick(); tick(); chk("mid_s6", state, 6);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_state", state, 0); chk("mid_rst_regwrite", regwrite, 0);
    chk("mid_rst_halt_state", h_state, 0);
    #1 reset = 1'b1;
    #1;
    chk("rel_irwrite", irwrite, 1); chk("rel_pcen", pcen, 1);
    tick(); chk("rel_s1", state, 1); chk("rel_h_s1", h_state, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
